// File: rtl/uart_link_pkg.sv
// Shared types and constants for the UART link receive/transmit helpers.
//   parser_state_t : frame parser FSM states
//   cmd_t          : which register a frame targets (switches or buttons)
//   ASCII_*        : framing characters
//   sat_inc8       : saturating 8-bit increment used by error counters
package uart_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    TERM   = 2'd2
  } parser_state_t;

  typedef enum logic {
    SW  = 1'b0,
    BTN = 1'b1
  } cmd_t;

  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_B  = 8'h42;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? 8'hFF : value + 8'd1;
  endfunction

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII hex-digit decoder.
//   ch     in  8 : ASCII character
//   is_hex out 1 : ch is one of 0-9, A-F, a-f
//   nibble out 4 : value of the digit (0 when is_hex is low)
module hex_ascii_decode (
  input  logic [7:0] ch,
  output logic       is_hex,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_hex = 1'b1;
      nibble = ch[3:0];
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
      is_hex = 1'b1;
      nibble = ch[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Receive-side frame parser: turns "Sxxxx<CR|LF>" and "Bxx<CR|LF>" byte
// streams into registered switch / button state.
//   clk, rst_n        : clock, asynchronous active-low reset
//   ena               : global enable; low freezes all state
//   rx_data, rx_valid : received character and its one-cycle strobe
//   switch_data       : last accepted switch value
//   button_data       : last accepted button value
//   sw_update         : one-cycle pulse when switch_data is loaded
//   btn_update        : one-cycle pulse when button_data is loaded
//   frame_err         : one-cycle pulse on a rejected or stalled frame
//   err_count         : saturating count of rejected frames
//   busy              : high while a frame is in progress
module uart_cmd_parser
  import uart_link_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int SWITCH_COUNT   = 16,
  parameter int BUTTON_COUNT   = 5,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic [SWITCH_COUNT-1:0] switch_data,
  output logic [BUTTON_COUNT-1:0] button_data,
  output logic                    sw_update,
  output logic                    btn_update,
  output logic                    frame_err,
  output logic [7:0]              err_count,
  output logic                    busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);

  parser_state_t state;
  cmd_t          cmd;
  logic [1:0]    digit_cnt;
  logic [15:0]   acc;
  logic [TW-1:0] idle_cnt;

  logic       is_hex;
  logic [3:0] nibble;
  logic [1:0] last_digit;
  logic       is_term;

  hex_ascii_decode u_hex (
    .ch     (rx_data),
    .is_hex (is_hex),
    .nibble (nibble)
  );

  assign last_digit = (cmd == SW) ? 2'd3 : 2'd1;
  assign is_term    = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd         <= SW;
      digit_cnt   <= 2'd0;
      acc         <= 16'h0000;
      idle_cnt    <= '0;
      switch_data <= '0;
      button_data <= '0;
      sw_update   <= 1'b0;
      btn_update  <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= 8'h00;
      busy        <= 1'b0;
    end else if (!ena) begin
      sw_update  <= 1'b0;
      btn_update <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sw_update  <= 1'b0;
      btn_update <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        IDLE: begin
          idle_cnt <= '0;
          // Anything that is not a start character is line noise.
          if (rx_valid && (rx_data == ASCII_S || rx_data == ASCII_B)) begin
            state     <= DIGITS;
            cmd       <= (rx_data == ASCII_S) ? SW : BTN;
            digit_cnt <= 2'd0;
            acc       <= 16'h0000;
            busy      <= 1'b1;
          end
        end

        DIGITS, TERM: begin
          if (rx_valid) begin
            // A byte on the would-be timeout cycle still wins.
            idle_cnt <= '0;
            if (state == DIGITS && is_hex) begin
              acc <= {acc[11:0], nibble};
              if (digit_cnt == last_digit) begin
                state     <= TERM;
                digit_cnt <= 2'd0;
              end else begin
                digit_cnt <= digit_cnt + 2'd1;
              end
            end else if (state == TERM && is_term) begin
              if (cmd == SW) begin
                switch_data <= acc[SWITCH_COUNT-1:0];
                sw_update   <= 1'b1;
              end else begin
                button_data <= acc[BUTTON_COUNT-1:0];
                btn_update  <= 1'b1;
              end
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              // Offending byte is consumed, never re-read as a start char.
              frame_err <= 1'b1;
              err_count <= sat_inc8(err_count);
              state     <= IDLE;
              busy      <= 1'b0;
            end
          end else if (idle_cnt == IDLE_LIMIT) begin
            // This silent cycle would bring the count to TIMEOUT_CYCLES.
            frame_err <= 1'b1;
            err_count <= sat_inc8(err_count);
            state     <= IDLE;
            busy      <= 1'b0;
            idle_cnt  <= '0;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames from the test plan
// followed by randomized frames, all compared cycle by cycle against a
// string-level frame model.
module tb_uart_cmd_parser;

  localparam int TO = 100;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] switch_data;
  logic [4:0]  button_data;
  logic        sw_update;
  logic        btn_update;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        busy;

  uart_cmd_parser #(
    .DATA_WIDTH     (8),
    .SWITCH_COUNT   (16),
    .BUTTON_COUNT   (5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .switch_data (switch_data),
    .button_data (button_data),
    .sw_update   (sw_update),
    .btn_update  (btn_update),
    .frame_err   (frame_err),
    .err_count   (err_count),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_txn = 0;

  // observed pulse counters, cleared by each directed test
  int n_swu, n_btnu, n_ferr;
  int last_byte_cyc, last_err_cyc;

  // reference model: the frame collected so far, as a byte string
  logic [7:0]  pend[$];
  int          idle_t;
  logic [15:0] m_sw;
  logic [4:0]  m_btn;
  logic        m_swu, m_btnu, m_err;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  task automatic model_reset();
    pend.delete();
    idle_t = 0;
    m_sw = 16'h0; m_btn = 5'h0;
    m_swu = 0; m_btnu = 0; m_err = 0;
    m_cnt = 0;
  endtask

  task automatic model_error();
    m_err = 1;
    if (m_cnt < 255) m_cnt++;
    pend.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int need, val;
    if (pend.size() == 0) begin
      if (b == "S" || b == "B") pend.push_back(b);
      return;
    end
    need = (pend[0] == "S") ? 4 : 2;
    if (pend.size() - 1 < need) begin
      if (hexval(b) >= 0) pend.push_back(b);
      else model_error();
    end else if (b == 8'h0D || b == 8'h0A) begin
      val = 0;
      for (int i = 1; i <= need; i++) val = val * 16 + hexval(pend[i]);
      if (pend[0] == "S") begin
        m_sw = val[15:0]; m_swu = 1;
      end else begin
        m_btn = val[4:0]; m_btnu = 1;
      end
      pend.delete();
    end else begin
      model_error();
    end
  endtask

  task automatic model_step(input logic en, input logic v, input logic [7:0] d);
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_swu = 0; m_btnu = 0; m_err = 0;
    if (!en) return;
    if (v) begin
      idle_t = 0;
      model_byte(d);
    end else if (pend.size() != 0) begin
      idle_t++;
      if (idle_t == TO) begin
        model_error();
        idle_t = 0;
      end
    end
  endtask

  task automatic check_all();
    check("switch_data", 32'(switch_data), 32'(m_sw));
    check("button_data", 32'(button_data), 32'(m_btn));
    check("sw_update",   32'(sw_update),   32'(m_swu));
    check("btn_update",  32'(btn_update),  32'(m_btnu));
    check("frame_err",   32'(frame_err),   32'(m_err));
    check("err_count",   32'(err_count),   32'(m_cnt));
    check("busy",        32'(busy),        32'(pend.size() != 0));
  endtask

  task automatic do_cycle(input logic en, input logic v, input logic [7:0] d);
    ena = en; rx_valid = v; rx_data = d;
    @(posedge clk);
    cyc++;
    model_step(en, v, d);
    #1;
    check_all();
    if (sw_update)  n_swu++;
    if (btn_update) n_btnu++;
    if (frame_err) begin
      n_ferr++;
      last_err_cyc = cyc;
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) do_cycle(1'b1, 1'b0, 8'h00);
    do_cycle(1'b1, 1'b1, b);
    last_byte_cyc = cyc;
  endtask

  task automatic send_str(input string s, input int gap);
    n_txn++;
    $display("txn %0d: directed %0d bytes, gap %0d, cycle %0d", n_txn, s.len(), gap, cyc);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic clear_obs();
    n_swu = 0; n_btnu = 0; n_ferr = 0;
  endtask

  function automatic logic [7:0] rand_hex();
    string digits;
    digits = "0123456789abcdefABCDEF";
    return digits[$urandom_range(0, 21)];
  endfunction

  task automatic rand_txn();
    logic [7:0] q[$];
    int kind, tail, pos;
    kind = $urandom_range(0, 9);
    tail = 0;
    if (kind <= 5 || kind == 6 || kind == 8) begin
      q.push_back((kind <= 3 || ($urandom_range(0, 1) == 0 && kind != 4 && kind != 5)) ? 8'h53 : 8'h42);
      for (int i = 0; i < ((q[0] == 8'h53) ? 4 : 2); i++) q.push_back(rand_hex());
      q.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
      if (kind == 6) begin
        pos = $urandom_range(1, q.size() - 1);
        q[pos] = $urandom_range(0, 1) ? 8'h78 : 8'h53;
      end
      if (kind == 8) begin
        // truncate and let the line go quiet around the timeout boundary
        q = q[0:$urandom_range(0, q.size() - 2)];
        tail = $urandom_range(TO - 5, TO + 5);
      end
    end else begin
      for (int i = 0; i < $urandom_range(1, 4); i++) q.push_back(8'($urandom_range(0, 255)));
    end
    n_txn++;
    $display("txn %0d: random kind %0d, %0d bytes, tail %0d, cycle %0d", n_txn, kind, q.size(), tail, cyc);
    foreach (q[i]) begin
      repeat ($urandom_range(0, 3)) do_cycle(($urandom_range(0, 7) != 0), 1'b0, 8'h00);
      do_cycle(($urandom_range(0, 15) != 0), 1'b1, q[i]);
    end
    repeat (tail) do_cycle(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    clear_obs();
    last_byte_cyc = 0; last_err_cyc = 0;
    repeat (3) do_cycle(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    check("reset_switch", 32'(switch_data), 32'h0);
    check("reset_errcnt", 32'(err_count), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // switch frame, mixed-case digits; gaps stay under the test timeout
    clear_obs();
    send_str("S1a2F\r", 20);
    repeat (3) do_cycle(1'b1, 1'b0, 8'h00);
    check("sw_value", 32'(switch_data), 32'h1A2F);
    check("sw_pulses", n_swu, 1);
    check("sw_errcnt", 32'(err_count), 32'h0);

    // two button frames; upper three accumulator bits are dropped
    clear_obs();
    send_str("B1F\n", 2);
    check("btn_value1", 32'(button_data), 32'h1F);
    send_str("B3C\n", 0);
    do_cycle(1'b1, 1'b0, 8'h00);
    check("btn_value2", 32'(button_data), 32'h1C);
    check("btn_pulses", n_btnu, 2);

    // bad digit: one error, trailing bytes ignored in IDLE
    clear_obs();
    send_str("S12G4\r", 1);
    repeat (3) do_cycle(1'b1, 1'b0, 8'h00);
    check("bad_errs", n_ferr, 1);
    check("bad_errcnt", 32'(err_count), 32'h1);
    check("bad_switch", 32'(switch_data), 32'h1A2F);

    // timeout fires on the TO-th silent cycle after the last byte
    clear_obs();
    send_str("S12", 0);
    repeat (TO) do_cycle(1'b1, 1'b0, 8'h00);
    check("to_latency", last_err_cyc - last_byte_cyc, TO);
    check("to_busy", 32'(busy), 32'h0);
    check("to_errs", n_ferr, 1);

    // a byte on the would-be timeout cycle wins
    clear_obs();
    send_str("S12", 0);
    send_byte("3", TO - 1);
    send_str("4\r", 0);
    do_cycle(1'b1, 1'b0, 8'h00);
    check("late_errs", n_ferr, 0);
    check("late_switch", 32'(switch_data), 32'h1234);

    // error counter saturation
    clear_obs();
    for (int i = 0; i < 300; i++) send_str("Sx", 0);
    check("sat_errcnt", 32'(err_count), 32'hFF);
    check("sat_errs", n_ferr, 300);

    // reset asserted mid-frame
    send_str("S1", 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_errcnt", 32'(err_count), 32'h0);
    do_cycle(1'b1, 1'b1, "2");
    rst_n = 1'b1;
    clear_obs();
    send_str("S00FF\r", 1);
    do_cycle(1'b1, 1'b0, 8'h00);
    check("post_rst_switch", 32'(switch_data), 32'h00FF);

    // ena low for 50 cycles mid-frame: no timeout, received bytes lost
    clear_obs();
    send_str("B1", 0);
    for (int i = 0; i < 50; i++) do_cycle(1'b0, 1'($urandom_range(0, 1)), 8'h0D);
    check("ena_busy", 32'(busy), 32'h1);
    send_str("5\n", 0);
    do_cycle(1'b1, 1'b0, 8'h00);
    check("ena_button", 32'(button_data), 32'h15);
    check("ena_errs", n_ferr, 0);

    // randomized frames against the model
    for (int t = 0; t < 400; t++) rand_txn();
    repeat (TO + 2) do_cycle(1'b1, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Decodes the received UART byte stream (`rx_data`/`rx_valid` from the `uart` core) into switch and button state for the Basys3 link. It is a per-byte frame parser alongside `uart_sr_input`, on the receive path. It produces registered `switch_data`/`button_data` with one-cycle update strobes. It also detects malformed or stalled frames and keeps a saturating error count.

## Interface
- `DATA_WIDTH`, 8: received character width (only 8 supported)
- `SWITCH_COUNT`, 16: switch bits, 4 hex digits
- `BUTTON_COUNT`, 5: button bits, from 2 hex digits
- `TIMEOUT_CYCLES`, 5_000_000: idle clocks tolerated mid-frame (100 ms at 50 MHz)
- `clk` in 1: system clock; the block uses one clock
- `rst_n` in 1: asynchronous, active-low reset
- `ena` in 1: when low, all state is frozen and input is ignored
- `rx_data` in 8: received character
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid this cycle
- `switch_data` out 16: last accepted switch value
- `button_data` out 5: last accepted button value
- `sw_update` out 1: one-cycle pulse; `switch_data` changed source
- `btn_update` out 1: one-cycle pulse; `button_data` changed source
- `frame_err` out 1: one-cycle pulse on a rejected frame
- `err_count` out 8: rejected frames, saturating at 255
- `busy` out 1: high while not in IDLE

## Operation
- Frame formats:
  - Switch frame: `'S'` (0x53), then 4 hex digits, then a terminator.
  - Button frame: `'B'` (0x42), then 2 hex digits, then a terminator.
- Terminator is CR (0x0D) or LF (0x0A).
- Hex digits are `0-9`, `A-F` and `a-f`. Digits are MSB first. The accumulator does `acc <= {acc[11:0], nibble}`.
- States are IDLE, DIGITS and TERM. A `cmd` register (SW/BTN) and a digit counter (0..3) hold frame progress.
- IDLE:
  - `'S'` → DIGITS, cmd=SW, cnt=0, acc=0.
  - `'B'` → DIGITS, cmd=BTN, cnt=0, acc=0.
  - Any other byte is dropped silently. No error is raised.
- DIGITS:
  - A hex byte shifts into `acc` and increments cnt.
  - After the 4th digit (SW) or 2nd digit (BTN), go to TERM.
  - A non-hex byte gives an error and returns to IDLE. The byte is discarded and not reinterpreted as a start char.
- TERM:
  - CR/LF on a SW frame: `switch_data <= acc[15:0]`, pulse `sw_update`.
  - CR/LF on a BTN frame: `button_data <= acc[4:0]`, pulse `btn_update`. `acc[7:5]` is ignored.
  - Go to IDLE.
  - Any other byte gives an error and returns to IDLE.
- Timeout:
  - An idle counter clears on every accepted byte and on entry to IDLE.
  - It increments on each `ena` cycle in DIGITS/TERM without `rx_valid`.
  - When it reaches `TIMEOUT_CYCLES`, raise an error and go to IDLE.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- Error handling: pulse `frame_err`, then `err_count <= (err_count==255) ? 255 : err_count+1`. `switch_data` and `button_data` are untouched.
- `ena`=0: no state, counter or output register changes. Pulses are forced low. A `rx_valid` during `ena`=0 is lost.

## Timing
- Reset values: `switch_data`=0, `button_data`=0, `sw_update`/`btn_update`/`frame_err`=0, `err_count`=0, `busy`=0, state IDLE, `acc`=0, counters 0.
- All outputs are registered.
- Latency: terminator sampled with `rx_valid` at edge N → new data and update pulse visible in cycle N+1, for exactly one cycle.
- Error pulse: `frame_err` is high in the cycle after the offending byte or timeout edge. `err_count` updates in the same cycle.
- Back-to-back bytes, one per cycle, are accepted with no stall. The block has no ready output.
- `rx_valid` on the cycle the timeout would fire: the byte wins. It is processed normally and the counter clears.
- Update and error pulses are mutually exclusive in any cycle.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded.

## Structure
- Package `uart_link_pkg` holds:
  - the `parser_state_t` enum (IDLE/DIGITS/TERM);
  - the `cmd_t` enum (SW/BTN);
  - the ASCII constants `ASCII_S`, `ASCII_B`, `ASCII_CR`, `ASCII_LF`.
- Sub-module `hex_ascii_decode` is combinational. It maps `[7:0]` to `{is_hex, nibble[3:0]}`. It is reused later by the TX-side formatter.
- The FSM, accumulator, timeout counter and error counter live in `uart_cmd_parser`.

## Test plan
- Stream `"S1a2F\r"`, one byte every 434 cycles → `switch_data`=16'h1A2F, single `sw_update` pulse one cycle after CR, `err_count`=0.
- Stream `"B1F\n"`, then `"B3C\n"` → `button_data`=5'h1F, then 5'h1C, two `btn_update` pulses.
- Stream `"S12G4\r"` → `frame_err` pulse after `'G'`, `err_count`=1, `switch_data` unchanged. The trailing `"4\r"` is ignored and causes no further error.
- Send `"S12"`, then silence for `TIMEOUT_CYCLES` (test value 100) → `frame_err` at cycle 100 after `'2'`, `busy`→0. Repeat with a byte arriving at cycle 100 → no error.
- Send 300 bad frames `"Sx"` → `err_count` saturates at 255.
- Assert reset mid-`"S12"`, and separately hold `ena`=0 for 50 cycles mid-frame → after reset, all outputs are 0 and a fresh `"S00FF\r"` gives 16'h00FF. During `ena`=0 there is no timeout and the frame completes after `ena` returns.
